// File: rtl/escalonador_mapas_pkg.sv
`default_nettype none
// ============================================================================
// Module      : escalonador_mapas_pkg
// Description : Shared state encoding, default parameters and row helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package escalonador_mapas_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SCAN  = 2'd1,
        ST_BLANK = 2'd2
    } estado_t;

    localparam int c_DIV_DEFAULT          = 50000;
    localparam int c_ROWS_DEFAULT         = 5;
    localparam int c_BLANK_FRAMES_DEFAULT = 4;
    localparam int c_ROW_W                = 7;
    localparam int c_ADDR_W               = 3;

    function automatic logic [c_ADDR_W-1:0] proxima_linha(
        input logic [c_ADDR_W-1:0] addr,
        input logic [c_ADDR_W-1:0] ultima
    );
        return (addr == ultima) ? '0 : addr + c_ADDR_W'(1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/escalonador_mapas_if.sv
`default_nettype none
// ============================================================================
// Module      : escalonador_mapas_if
// Description : Map-storage and LED-matrix signals of the scan scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
interface escalonador_mapas_if
    import escalonador_mapas_pkg::*;
#(
    parameter int ROWS = c_ROWS_DEFAULT
);
    logic [c_ROW_W-1:0]  mapa0_linha;
    logic [c_ROW_W-1:0]  mapa1_linha;
    logic [c_ADDR_W-1:0] linha_addr;
    logic                sel;
    logic                jogador;
    logic [ROWS-1:0]     linha_en;
    logic [c_ROW_W-1:0]  colunas;
    logic                trocando;

    modport master (
        input  mapa0_linha, mapa1_linha,
        output linha_addr, sel, jogador, linha_en, colunas, trocando
    );

    modport slave (
        output mapa0_linha, mapa1_linha,
        input  linha_addr, sel, jogador, linha_en, colunas, trocando
    );
endinterface
`default_nettype wire

// File: rtl/mux_2mapas_x1.sv
`default_nettype none
// ============================================================================
// Module      : mux_2mapas_x1
// Description : 7-bit row mux selecting between the two players' maps.
// Revision    : 1.0 - initial release
// ============================================================================
module mux_2mapas_x1
    import escalonador_mapas_pkg::*;
(
    input  wire logic [c_ROW_W-1:0] i_mapa0,
    input  wire logic [c_ROW_W-1:0] i_mapa1,
    input  wire logic               i_sel,
    output logic      [c_ROW_W-1:0] o_linha
);
    assign o_linha = i_sel ? i_mapa1 : i_mapa0;
endmodule
`default_nettype wire

// File: rtl/escalonador_mapas.sv
`default_nettype none
// ============================================================================
// Module      : escalonador_mapas
// Description : Row-scan and player-turn scheduler for the 2-map LED display.
// Revision    : 1.0 - initial release
// ============================================================================
module escalonador_mapas
    import escalonador_mapas_pkg::*;
#(
    parameter int DIV          = c_DIV_DEFAULT,
    parameter int ROWS         = c_ROWS_DEFAULT,
    parameter int BLANK_FRAMES = c_BLANK_FRAMES_DEFAULT
)(
    input  wire logic clk,
    input  wire logic reset,
    input  wire logic en,
    input  wire logic btn_troca,
    escalonador_mapas_if.master bus
);
    localparam int c_PRESC_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int c_FRM_W   = (BLANK_FRAMES > 1) ? $clog2(BLANK_FRAMES) : 1;
    localparam logic [c_PRESC_W-1:0] c_PRESC_MAX = c_PRESC_W'(DIV - 1);
    localparam logic [c_ADDR_W-1:0]  c_LAST_ROW  = c_ADDR_W'(ROWS - 1);
    localparam logic [c_FRM_W-1:0]   c_FRM_LOAD  = c_FRM_W'(BLANK_FRAMES - 1);

    estado_t             estado_q,     estado_d;
    logic [c_PRESC_W-1:0] presc_q,     presc_d;
    logic [c_ADDR_W-1:0] linha_addr_q, linha_addr_d;
    logic                jogador_q,    jogador_d;
    logic [ROWS-1:0]     linha_en_q,   linha_en_d;
    logic [c_ROW_W-1:0]  colunas_q,    colunas_d;
    logic                trocando_q,   trocando_d;
    logic                pedido_q,     pedido_d;
    logic [c_FRM_W-1:0]  frame_q,      frame_d;
    logic                btn_hist_q,   btn_hist_d;

    logic                w_tick;
    logic                w_eof;
    logic                w_borda;
    logic [c_PRESC_W-1:0] w_presc_next;
    logic [c_ADDR_W-1:0] w_addr_next;
    logic [c_ROW_W-1:0]  w_linha_mux;

    mux_2mapas_x1 u_mux (
        .i_mapa0 (bus.mapa0_linha),
        .i_mapa1 (bus.mapa1_linha),
        .i_sel   (jogador_q),
        .o_linha (w_linha_mux)
    );

    assign w_tick       = (presc_q == c_PRESC_MAX);
    assign w_eof        = w_tick && (linha_addr_q == c_LAST_ROW);
    assign w_borda      = btn_troca && !btn_hist_q;
    assign w_presc_next = w_tick ? '0 : presc_q + c_PRESC_W'(1);
    assign w_addr_next  = w_tick ? proxima_linha(linha_addr_q, c_LAST_ROW) : linha_addr_q;

    always_comb begin
        estado_d     = estado_q;
        presc_d      = presc_q;
        linha_addr_d = linha_addr_q;
        jogador_d    = jogador_q;
        linha_en_d   = linha_en_q;
        colunas_d    = colunas_q;
        trocando_d   = trocando_q;
        pedido_d     = pedido_q;
        frame_d      = frame_q;
        btn_hist_d   = btn_troca;

        if (!en) begin
            estado_d     = ST_IDLE;
            presc_d      = '0;
            linha_addr_d = '0;
            linha_en_d   = '0;
            colunas_d    = '0;
            trocando_d   = 1'b0;
            pedido_d     = 1'b0;
            frame_d      = '0;
        end else begin
            case (estado_q)
                ST_IDLE: begin
                    presc_d      = '0;
                    linha_addr_d = '0;
                    linha_en_d   = '0;
                    colunas_d    = '0;
                    estado_d     = ST_SCAN;
                end
                ST_SCAN: begin
                    presc_d      = w_presc_next;
                    linha_addr_d = w_addr_next;
                    linha_en_d   = ROWS'(1) << linha_addr_q;
                    colunas_d    = w_linha_mux;
                    // An edge on the closing tick only arms the request; the swap waits a frame.
                    if (w_eof && pedido_q) begin
                        estado_d   = ST_BLANK;
                        pedido_d   = 1'b0;
                        frame_d    = c_FRM_LOAD;
                        trocando_d = 1'b1;
                    end else if (w_borda) begin
                        pedido_d = 1'b1;
                    end
                end
                ST_BLANK: begin
                    presc_d      = w_presc_next;
                    linha_addr_d = w_addr_next;
                    linha_en_d   = '0;
                    colunas_d    = '0;
                    if (w_eof) begin
                        if (frame_q == '0) begin
                            jogador_d  = !jogador_q;
                            trocando_d = 1'b0;
                            estado_d   = ST_SCAN;
                        end else begin
                            frame_d = frame_q - c_FRM_W'(1);
                        end
                    end
                end
                default: estado_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            estado_q     <= ST_IDLE;
            presc_q      <= '0;
            linha_addr_q <= '0;
            jogador_q    <= 1'b0;
            linha_en_q   <= '0;
            colunas_q    <= '0;
            trocando_q   <= 1'b0;
            pedido_q     <= 1'b0;
            frame_q      <= '0;
            btn_hist_q   <= 1'b0;
        end else begin
            estado_q     <= estado_d;
            presc_q      <= presc_d;
            linha_addr_q <= linha_addr_d;
            jogador_q    <= jogador_d;
            linha_en_q   <= linha_en_d;
            colunas_q    <= colunas_d;
            trocando_q   <= trocando_d;
            pedido_q     <= pedido_d;
            frame_q      <= frame_d;
            btn_hist_q   <= btn_hist_d;
        end
    end

    assign bus.linha_addr = linha_addr_q;
    assign bus.jogador    = jogador_q;
    assign bus.sel        = jogador_q;
    assign bus.linha_en   = linha_en_q;
    assign bus.colunas    = colunas_q;
    assign bus.trocando   = trocando_q;

endmodule
`default_nettype wire

// File: tb/tb_escalonador_mapas.sv
`default_nettype none
// ============================================================================
// Module      : tb_escalonador_mapas
// Description : Scoreboard bench for the map scan/turn scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_escalonador_mapas;
    localparam int DIV  = 4;
    localparam int ROWS = 5;
    localparam int BF   = 2;
    localparam int F    = ROWS * DIV;

    logic clk = 1'b0;
    logic reset, en, btn_troca;
    logic [6:0] map0 [8];
    logic [6:0] map1 [8];

    escalonador_mapas_if #(.ROWS(ROWS)) bus ();

    assign bus.mapa0_linha = map0[bus.linha_addr];
    assign bus.mapa1_linha = map1[bus.linha_addr];

    escalonador_mapas #(.DIV(DIV), .ROWS(ROWS), .BLANK_FRAMES(BF)) dut (
        .clk       (clk),
        .reset     (reset),
        .en        (en),
        .btn_troca (btn_troca),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]      addr;
        logic            jog;
        logic [ROWS-1:0] len;
        logic [6:0]      col;
        logic            troc;
    } exp_t;

    exp_t sb [$];
    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: a continuous scan timeline t, with the swap scheduled
    // as an absolute time BF frames after the blank begins.
    int          mode;      // 0 idle, 1 scanning, 2 blanking
    int unsigned t;
    int unsigned swap_at;
    bit          jog, pend, btn_prev;
    logic [ROWS-1:0] m_en;
    logic [6:0]  m_col;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int cur_row();
        return int'((t / DIV) % ROWS);
    endfunction

    initial begin : monitor
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                x = sb.pop_front();
                chk("linha_addr", 32'(bus.linha_addr), 32'(x.addr));
                chk("jogador",    32'(bus.jogador),    32'(x.jog));
                chk("sel",        32'(bus.sel),        32'(x.jog));
                chk("linha_en",   32'(bus.linha_en),   32'(x.len));
                chk("colunas",    32'(bus.colunas),    32'(x.col));
                chk("trocando",   32'(bus.trocando),   32'(x.troc));
            end
        end
    end

    // Called half a cycle before a rising edge: drive inputs, predict the
    // post-edge outputs, queue them, then wait for the next drive slot.
    task automatic step(input bit r, input bit e, input bit b);
        bit   edge_b, eof;
        int   row;
        exp_t x;
        reset = r; en = e; btn_troca = b;
        if (r) begin
            mode = 0; t = 0; jog = 0; pend = 0; btn_prev = 0;
            m_en = '0; m_col = '0;
            #1;
            chk("rst_imm_linha_en", 32'(bus.linha_en), 32'd0);
            chk("rst_imm_colunas",  32'(bus.colunas),  32'd0);
            chk("rst_imm_jogador",  32'(bus.jogador),  32'd0);
            chk("rst_imm_trocando", 32'(bus.trocando), 32'd0);
        end else begin
            edge_b = b && !btn_prev;
            btn_prev = b;
            if (!e) begin
                mode = 0; t = 0; pend = 0; m_en = '0; m_col = '0;
            end else if (mode == 0) begin
                mode = 1; t = 0; m_en = '0; m_col = '0;
            end else begin
                row = cur_row();
                eof = ((t % F) == F - 1);
                if (mode == 1) begin
                    m_en  = ROWS'(1) << row;
                    m_col = jog ? map1[row] : map0[row];
                    if (eof && pend) begin
                        mode = 2; pend = 0; swap_at = t + 1 + BF * F;
                    end else if (edge_b) begin
                        pend = 1;
                    end
                end else begin
                    m_en = '0; m_col = '0;
                    if (t + 1 == swap_at) begin
                        jog = !jog; mode = 1;
                    end
                end
                t++;
            end
        end
        x.addr = 3'(cur_row());
        x.jog  = jog;
        x.len  = m_en;
        x.col  = m_col;
        x.troc = (mode == 2);
        sb.push_back(x);
        @(negedge clk);
        #1;
    endtask

    task automatic run(input int n, input bit b);
        for (int i = 0; i < n; i++) step(1'b0, 1'b1, b);
    endtask

    task automatic run_until_mode(input int want, input int budget, input string nm);
        int k;
        for (k = 0; k < budget && mode != want; k++) run(1, 1'b0);
        chk(nm, 32'(mode), 32'(want));
    endtask

    initial begin : driver
        int k;
        bit rb, eb, bb;
        reset = 1'b1; en = 1'b0; btn_troca = 1'b0;
        for (int i = 0; i < 8; i++) begin
            map0[i] = 7'b1000001;
            map1[i] = 7'b1100011;
        end
        mode = 0; t = 0; swap_at = 0; jog = 0; pend = 0; btn_prev = 0;
        m_en = '0; m_col = '0;
        @(negedge clk);
        #1;

        // Reset, then steady scan of player 0
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        run(30, 1'b0);

        // Swap request at row 2
        for (k = 0; k < 40 && !(mode == 1 && cur_row() == 2); k++) run(1, 1'b0);
        chk("wait_row2", 32'(cur_row()), 32'd2);
        run(1, 1'b1);
        run(1, 1'b0);
        run_until_mode(2, 2 * F, "reach_blank_b");
        run_until_mode(1, (BF + 1) * F, "reach_scan_b");
        run(25, 1'b0);

        // Request on the closing tick, second edge during blanking
        for (k = 0; k < 2 * F && !(mode == 1 && (t % F) == F - 1); k++) run(1, 1'b0);
        chk("wait_eof", 32'(t % F), 32'(F - 1));
        run(1, 1'b1);
        run(1, 1'b0);
        run_until_mode(2, 3 * F, "reach_blank_c");
        run(7, 1'b0);
        run(2, 1'b1);
        run(1, 1'b0);
        run_until_mode(1, (BF + 1) * F, "reach_scan_c");
        run(2 * F, 1'b0);

        // Enable dropped while blanking
        run(1, 1'b1);
        run(1, 1'b0);
        run_until_mode(2, 2 * F, "reach_blank_d");
        run(5, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0);
        run(2 * F + 3, 1'b0);

        // Button held for three frames
        run(3 * F, 1'b1);
        run((BF + 3) * F, 1'b0);

        // Async reset while blanking with player 1 active
        if (!jog) begin
            run(1, 1'b1);
            run(1, 1'b0);
            run_until_mode(1, (BF + 3) * F, "prep_jog1");
        end
        run(1, 1'b1);
        run(1, 1'b0);
        run_until_mode(2, 2 * F, "reach_blank_f");
        run(9, 1'b0);
        chk("prep_jog_is_1", 32'(bus.jogador), 32'd1);
        step(1'b1, 1'b1, 1'b0);
        run(F + 4, 1'b0);

        // Randomized traffic with fresh map contents
        bb = 1'b0;
        for (int c = 0; c < 4000; c++) begin
            if (c % 200 == 0) begin
                for (int i = 0; i < 8; i++) begin
                    map0[i] = 7'($urandom);
                    map1[i] = 7'($urandom);
                end
            end
            if ($urandom_range(0, 29) == 0) bb = !bb;
            eb = ($urandom_range(0, 399) != 0);
            rb = ($urandom_range(0, 1499) == 0);
            step(rb, eb, bb);
        end

        @(posedge clk);
        #2;
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/escalonador_mapas.md
# escalonador_mapas

Scan and turn scheduler for the two-player map display. It time-multiplexes the current player's 7-column map rows onto a ROWS-row LED matrix. It drives the select line of the 2-map row mux and the row address into map storage. On a debounced swap button it finishes the current frame, blanks the display for BLANK_FRAMES frames, then hands the display to the other player.

## Interface
- DIV, default 50000: clock cycles per row slot; legal range ≥ 2.
- ROWS, default 5: matrix rows; legal range 2..8.
- BLANK_FRAMES, default 4: full blank frames shown between players; legal range ≥ 1.
- clk  input  1  system clock; all state changes on its rising edge.
- reset  input  1  asynchronous, active-high; clears all state.
- en  input  1  display enable; low forces IDLE.
- btn_troca  input  1  debounced, synchronous swap request (level); rising edge is the event.
- mapa0_linha  input  7  row data of player 0's map at address linha_addr (combinational from storage).
- mapa1_linha  input  7  row data of player 1's map at address linha_addr.
- linha_addr  output  3  registered row address to map storage.
- sel  output  1  mux select, equal to jogador.
- jogador  output  1  registered current player (0/1).
- linha_en  output  ROWS  registered one-hot row drive, active-high.
- colunas  output  7  registered column data for the driven row.
- trocando  output  1  high while in BLANK.

## Operation
- States: IDLE, SCAN, BLANK.
- Reset values: state IDLE, prescaler 0, linha_addr 0, jogador 0, sel 0, linha_en 0, colunas 0, trocando 0, pedido 0, frame counter 0, btn_troca history 0.
- Reset mid-operation: immediately returns every register to its reset value, including jogador.
- IDLE: outputs blank (linha_en 0, colunas 0), prescaler and row held at 0. en=1 moves to SCAN on the next edge.
- tick = (prescaler == DIV-1). The prescaler wraps to 0 on tick. It counts only in SCAN and BLANK.
- SCAN, on tick: linha_addr advances by 1, wrapping from ROWS-1 to 0. End of frame is a tick with linha_addr == ROWS-1.
- SCAN output stage, every cycle: linha_en <= one-hot(linha_addr), colunas <= (sel ? mapa1_linha : mapa0_linha).
- Swap request: a rising edge of btn_troca (registered history) in SCAN sets pedido. Further edges while pedido=1 are ignored.
- End of frame with pedido=1: go to BLANK, clear pedido, load frame counter with BLANK_FRAMES-1, set trocando.
- End of frame with pedido=0: stay in SCAN.
- BLANK: linha_en 0, colunas 0, and row scanning continues unchanged. Edges of btn_troca are ignored and do not set pedido.
- BLANK, each end of frame: decrement the frame counter. At an end of frame with the counter at 0: toggle jogador, clear trocando, go to SCAN. The row is then 0.
- Request edge in the same cycle as end of frame: it sets pedido but does not trigger that frame's swap. The swap happens at the following end of frame.
- en=0 in any state: next edge goes to IDLE, clears pedido, frame counter and trocando. jogador is kept.

## Timing
- Outputs update 1 cycle after linha_addr: the map data for row r appears on colunas/linha_en one edge after linha_addr becomes r.
- Row slot = DIV cycles; frame = ROWS·DIV cycles.
- Swap latency from the request edge: remainder of the current frame + BLANK_FRAMES·ROWS·DIV cycles.
- The first SCAN output after BLANK carries the new jogador's row 0 on the cycle after the transition.
- sel changes only on the BLANK→SCAN edge, never mid-frame.

## Structure
- Shared constants file: state encodings (IDLE=2'd0, SCAN=2'd1, BLANK=2'd2), default DIV/ROWS/BLANK_FRAMES, and row-data width 7.
- One sub-module instantiated: the existing 7-bit map mux, mux_2mapas_x1, fed by mapa0_linha/mapa1_linha/sel. Its output feeds the colunas register.
- Everything else (prescaler, row counter, FSM, edge detect, frame counter) lives in one module.

## Test plan
- Reset mid-BLANK with jogador=1: assert reset asynchronously → all outputs 0 immediately, jogador 0. Release with en=1 → SCAN, linha_addr 0.
- Scan, DIV=4, ROWS=5, mapa0_linha=7'b1000001: linha_addr steps 0,1,2,3,4,0 every 4 cycles. linha_en follows as 00001…10000 one cycle later. colunas=1000001.
- Swap, BLANK_FRAMES=2: pulse btn_troca at row 2 → trocando rises at the end of that frame. Blank for 40 cycles, then jogador=1, sel=1, colunas=mapa1_linha (7'b1100011).
- Request edge on the end-of-frame tick: swap deferred exactly one frame. A second edge in BLANK is ignored, giving exactly one toggle.
- en deasserted in BLANK: IDLE next cycle, outputs 0, trocando 0, jogador unchanged. Re-enable → SCAN at row 0 with no pending swap.
- btn_troca held high for 3 frames: only one swap occurs.
